// File: rtl/vga_vram_arbiter_if.sv
// Video RAM arbiter bus: display fetch, game-logic port, RAM side and status flags.
interface vga_vram_arbiter_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 9
);
    logic                  i_Blank;
    logic                  i_VBlank;
    logic                  i_Disp_Req;
    logic [ADDR_WIDTH-1:0] i_Disp_Addr;
    logic                  o_Disp_Valid;
    logic [DATA_WIDTH-1:0] o_Disp_Data;
    logic                  i_Cpu_Req;
    logic                  i_Cpu_We;
    logic [ADDR_WIDTH-1:0] i_Cpu_Addr;
    logic [DATA_WIDTH-1:0] i_Cpu_Wdata;
    logic                  o_Cpu_Ack;
    logic                  o_Cpu_Rvalid;
    logic [DATA_WIDTH-1:0] o_Cpu_Rdata;
    logic                  o_Mem_En;
    logic                  o_Mem_We;
    logic [ADDR_WIDTH-1:0] o_Mem_Addr;
    logic [DATA_WIDTH-1:0] o_Mem_Wdata;
    logic [DATA_WIDTH-1:0] i_Mem_Rdata;
    logic                  o_Starve;
    logic                  i_Starve_Clr;
    logic                  o_VBlank_Tick;

    modport slave (
        input  i_Blank, i_VBlank, i_Disp_Req, i_Disp_Addr,
        input  i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
        input  i_Mem_Rdata, i_Starve_Clr,
        output o_Disp_Valid, o_Disp_Data, o_Cpu_Ack, o_Cpu_Rvalid, o_Cpu_Rdata,
        output o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Starve, o_VBlank_Tick
    );

    modport master (
        output i_Blank, i_VBlank, i_Disp_Req, i_Disp_Addr,
        output i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
        output i_Mem_Rdata, i_Starve_Clr,
        input  o_Disp_Valid, o_Disp_Data, o_Cpu_Ack, o_Cpu_Rvalid, o_Cpu_Rdata,
        input  o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_Wdata, o_Starve, o_VBlank_Tick
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, game logic takes blanking/idle
// slots. Also tracks game-logic starvation and emits a vertical-blank-start tick.
module vga_vram_arbiter #(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 9,
    parameter int CPU_IN_ACTIVE = 1,
    parameter int STARVE_LIMIT  = 1024,
    parameter int CNT_WIDTH     = 11
) (
    input logic                i_Clk,
    input logic                i_Rst_L,
    vga_vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DISP, CPU} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CPU} tag_t;

    localparam bit                   CPU_ACTIVE_OK = (CPU_IN_ACTIVE != 0);
    localparam logic [CNT_WIDTH-1:0] STARVE_SET    = CNT_WIDTH'(STARVE_LIMIT - 1);

    state_t                state;
    tag_t                  rd_tag_q;
    logic [CNT_WIDTH-1:0]  starve_cnt;
    logic                  vblank_q;
    logic                  grant_disp;
    logic                  grant_cpu;

    always_comb begin
        grant_disp = bus.i_Disp_Req;
        grant_cpu  = !bus.i_Disp_Req && bus.i_Cpu_Req && (bus.i_Blank || CPU_ACTIVE_OK);
    end

    // state names the owner of the command currently presented to the RAM
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state           <= IDLE;
            bus.o_Mem_En    <= 1'b0;
            bus.o_Mem_We    <= 1'b0;
            bus.o_Mem_Addr  <= '0;
            bus.o_Mem_Wdata <= '0;
            bus.o_Cpu_Ack   <= 1'b0;
        end else if (grant_disp) begin
            state           <= DISP;
            bus.o_Mem_En    <= 1'b1;
            bus.o_Mem_We    <= 1'b0;
            bus.o_Mem_Addr  <= bus.i_Disp_Addr;
            bus.o_Cpu_Ack   <= 1'b0;
        end else if (grant_cpu) begin
            state           <= CPU;
            bus.o_Mem_En    <= 1'b1;
            bus.o_Mem_We    <= bus.i_Cpu_We;
            bus.o_Mem_Addr  <= bus.i_Cpu_Addr;
            bus.o_Mem_Wdata <= bus.i_Cpu_Wdata;
            bus.o_Cpu_Ack   <= 1'b1;
        end else begin
            state           <= IDLE;
            bus.o_Mem_En    <= 1'b0;
            bus.o_Mem_We    <= 1'b0;
            bus.o_Cpu_Ack   <= 1'b0;
        end
    end

    // Second tag stage lines up with i_Mem_Rdata; the first stage is the FSM state itself.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rd_tag_q         <= TAG_NONE;
            bus.o_Disp_Valid <= 1'b0;
            bus.o_Disp_Data  <= '0;
            bus.o_Cpu_Rvalid <= 1'b0;
            bus.o_Cpu_Rdata  <= '0;
        end else begin
            case (state)
                DISP:    rd_tag_q <= TAG_DISP;
                CPU:     rd_tag_q <= bus.o_Mem_We ? TAG_NONE : TAG_CPU;
                default: rd_tag_q <= TAG_NONE;
            endcase
            bus.o_Disp_Valid <= (rd_tag_q == TAG_DISP);
            bus.o_Cpu_Rvalid <= (rd_tag_q == TAG_CPU);
            if (rd_tag_q == TAG_DISP) bus.o_Disp_Data <= bus.i_Mem_Rdata;
            if (rd_tag_q == TAG_CPU)  bus.o_Cpu_Rdata <= bus.i_Mem_Rdata;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            starve_cnt   <= '0;
            bus.o_Starve <= 1'b0;
        end else if (bus.i_Starve_Clr) begin
            starve_cnt   <= '0;
            bus.o_Starve <= 1'b0;
        end else if (!bus.i_Cpu_Req || grant_cpu) begin
            starve_cnt   <= '0;
        end else begin
            if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            // this cycle is the STARVE_LIMIT-th consecutive ungranted one
            if (starve_cnt >= STARVE_SET) bus.o_Starve <= 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vblank_q          <= 1'b0;
            bus.o_VBlank_Tick <= 1'b0;
        end else begin
            vblank_q          <= bus.i_VBlank;
            bus.o_VBlank_Tick <= bus.i_VBlank && !vblank_q;
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a behavioural synchronous RAM model.
module tb_vga_vram_arbiter;
    localparam int AW = 13;
    localparam int DW = 9;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vga_vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    vga_vram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_IN_ACTIVE(0),
        .STARVE_LIMIT(1024), .CNT_WIDTH(11)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM, one-cycle read latency, preloaded with RAM[a]=a.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    end
    always @(posedge clk) begin
        if (bus.o_Mem_En) begin
            if (bus.o_Mem_We) ram[bus.o_Mem_Addr] <= bus.o_Mem_Wdata;
            else              bus.i_Mem_Rdata <= ram[bus.o_Mem_Addr];
        end
    end

    typedef struct {
        logic          disp_req;
        logic          cpu_req;
        logic          cpu_we;
        logic          blank;
        logic [AW-1:0] disp_addr;
        logic [AW-1:0] cpu_addr;
        logic [DW-1:0] wdata;
        logic          exp_en;
        logic          exp_we;
        logic          chk_addr;
        logic [AW-1:0] exp_addr;
        logic          exp_ack;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_Blank = 0; bus.i_VBlank = 0; bus.i_Disp_Req = 0; bus.i_Disp_Addr = '0;
        bus.i_Cpu_Req = 0; bus.i_Cpu_We = 0; bus.i_Cpu_Addr = '0; bus.i_Cpu_Wdata = '0;
        bus.i_Starve_Clr = 0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.o_Disp_Valid, bus.o_Disp_Data, bus.o_Cpu_Ack, bus.o_Cpu_Rvalid,
                    bus.o_Mem_En, bus.o_Mem_We, bus.o_Starve, bus.o_VBlank_Tick}) |
               32'(bus.o_Cpu_Rdata) | 32'(bus.o_Mem_Addr) | 32'(bus.o_Mem_Wdata);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_Mem_Rdata = '0;
        idle_inputs();

        vecs[0] = '{0, 0, 0, 0, 13'h000, 13'h000, 9'h000, 0, 0, 0, 13'h000, 0};
        vecs[1] = '{1, 0, 0, 0, 13'h0AA, 13'h000, 9'h000, 1, 0, 1, 13'h0AA, 0};
        vecs[2] = '{0, 1, 1, 1, 13'h000, 13'h1F00, 9'h155, 1, 1, 1, 13'h1F00, 1};
        vecs[3] = '{0, 1, 0, 0, 13'h000, 13'h1F01, 9'h000, 0, 0, 0, 13'h000, 0};
        vecs[4] = '{0, 1, 0, 1, 13'h000, 13'h1F01, 9'h000, 1, 0, 1, 13'h1F01, 1};
        vecs[5] = '{1, 1, 1, 1, 13'h033, 13'h1F02, 9'h0F0, 1, 0, 1, 13'h033, 0};
        vecs[6] = '{0, 1, 1, 1, 13'h000, 13'h1FFF, 9'h0F0, 1, 1, 1, 13'h1FFF, 1};

        step();
        step();
        chk("reset_outputs", all_outs(), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_reset_outputs", all_outs(), 32'h0);

        for (int v = 0; v < 7; v++) begin
            bus.i_Disp_Req  = vecs[v].disp_req;
            bus.i_Cpu_Req   = vecs[v].cpu_req;
            bus.i_Cpu_We    = vecs[v].cpu_we;
            bus.i_Blank     = vecs[v].blank;
            bus.i_Disp_Addr = vecs[v].disp_addr;
            bus.i_Cpu_Addr  = vecs[v].cpu_addr;
            bus.i_Cpu_Wdata = vecs[v].wdata;
            step();
            chk($sformatf("vec%0d_en", v),  32'(bus.o_Mem_En),  32'(vecs[v].exp_en));
            chk($sformatf("vec%0d_we", v),  32'(bus.o_Mem_We),  32'(vecs[v].exp_we));
            chk($sformatf("vec%0d_ack", v), 32'(bus.o_Cpu_Ack), 32'(vecs[v].exp_ack));
            if (vecs[v].chk_addr)
                chk($sformatf("vec%0d_addr", v), 32'(bus.o_Mem_Addr), 32'(vecs[v].exp_addr));
            if (vecs[v].exp_we)
                chk($sformatf("vec%0d_wdata", v), 32'(bus.o_Mem_Wdata), 32'(vecs[v].wdata));
        end
        idle_inputs();
        step();
        step();
        step();

        // Display burst 0x010..0x01F, data appears two edges after each request.
        for (int c = 0; c < 19; c++) begin
            bus.i_Disp_Req  = (c < 16);
            bus.i_Disp_Addr = AW'(16 + c);
            step();
            chk($sformatf("burst_valid_c%0d", c), 32'(bus.o_Disp_Valid), 32'(c >= 2 && c < 18));
            if (c >= 2 && c < 18)
                chk($sformatf("burst_data_c%0d", c), 32'(bus.o_Disp_Data), 32'(16 + c - 2));
        end

        // Game-logic write held off through active video, granted in first blank cycle.
        bus.i_Cpu_Req = 1; bus.i_Cpu_We = 1; bus.i_Cpu_Addr = 13'h100; bus.i_Cpu_Wdata = 9'h1A5;
        for (int c = 0; c < 4; c++) begin
            bus.i_Disp_Req  = (c < 3);
            bus.i_Disp_Addr = AW'(13'h040 + c);
            step();
            chk($sformatf("active_noack_c%0d", c), 32'(bus.o_Cpu_Ack), 32'h0);
        end
        bus.i_Blank = 1;
        step();
        chk("wr_ack", 32'(bus.o_Cpu_Ack), 32'h1);
        chk("wr_mem_we", 32'(bus.o_Mem_We), 32'h1);
        chk("wr_mem_addr", 32'(bus.o_Mem_Addr), 32'h100);
        chk("wr_mem_wdata", 32'(bus.o_Mem_Wdata), 32'h1A5);
        bus.i_Cpu_We = 0;
        step();
        chk("rd_ack", 32'(bus.o_Cpu_Ack), 32'h1);
        chk("rd_mem_we", 32'(bus.o_Mem_We), 32'h0);
        bus.i_Cpu_Req = 0;
        step();
        chk("rd_rvalid_early", 32'(bus.o_Cpu_Rvalid), 32'h0);
        step();
        chk("rd_rvalid", 32'(bus.o_Cpu_Rvalid), 32'h1);
        chk("rd_rdata", 32'(bus.o_Cpu_Rdata), 32'h1A5);
        step();
        chk("rd_rvalid_pulse", 32'(bus.o_Cpu_Rvalid), 32'h0);

        // Tie in blanking: display first, game read one cycle later, no cross delivery.
        bus.i_Disp_Req = 1; bus.i_Disp_Addr = 13'h020;
        bus.i_Cpu_Req = 1; bus.i_Cpu_We = 0; bus.i_Cpu_Addr = 13'h100;
        step();
        chk("tie_ack0", 32'(bus.o_Cpu_Ack), 32'h0);
        chk("tie_addr0", 32'(bus.o_Mem_Addr), 32'h020);
        bus.i_Disp_Req = 0;
        step();
        chk("tie_ack1", 32'(bus.o_Cpu_Ack), 32'h1);
        chk("tie_addr1", 32'(bus.o_Mem_Addr), 32'h100);
        bus.i_Cpu_Req = 0;
        step();
        chk("tie_disp_valid", 32'(bus.o_Disp_Valid), 32'h1);
        chk("tie_disp_data", 32'(bus.o_Disp_Data), 32'h020);
        chk("tie_no_rvalid", 32'(bus.o_Cpu_Rvalid), 32'h0);
        step();
        chk("tie_rvalid", 32'(bus.o_Cpu_Rvalid), 32'h1);
        chk("tie_rdata", 32'(bus.o_Cpu_Rdata), 32'h1A5);
        chk("tie_disp_done", 32'(bus.o_Disp_Valid), 32'h0);

        // Starvation: display hogs every slot.
        bus.i_Disp_Req = 1; bus.i_Disp_Addr = 13'h050;
        bus.i_Cpu_Req = 1; bus.i_Cpu_We = 0; bus.i_Cpu_Addr = 13'h060;
        for (int n = 1; n <= 1030; n++) begin
            step();
            if (n == 1023) chk("starve_before", 32'(bus.o_Starve), 32'h0);
            if (n == 1024) chk("starve_set", 32'(bus.o_Starve), 32'h1);
            if (n == 1030) chk("starve_sticky", 32'(bus.o_Starve), 32'h1);
        end
        bus.i_Starve_Clr = 1;
        step();
        chk("starve_clr", 32'(bus.o_Starve), 32'h0);
        bus.i_Starve_Clr = 0;
        step();
        chk("starve_restart", 32'(bus.o_Starve), 32'h0);
        idle_inputs();
        step();
        step();
        step();

        // Reset while a game read is in flight drops the read.
        bus.i_Blank = 1; bus.i_Cpu_Req = 1; bus.i_Cpu_Addr = 13'h100;
        step();
        chk("rst_rd_ack", 32'(bus.o_Cpu_Ack), 32'h1);
        bus.i_Cpu_Req = 0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", all_outs(), 32'h0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rst_no_rvalid_c%0d", c), 32'(bus.o_Cpu_Rvalid | bus.o_Disp_Valid), 32'h0);
        end
        chk("after_release_outputs", all_outs(), 32'h0);

        // Vertical blank tick.
        bus.i_VBlank = 1;
        step();
        chk("vblank_tick", 32'(bus.o_VBlank_Tick), 32'h1);
        step();
        chk("vblank_tick_pulse", 32'(bus.o_VBlank_Tick), 32'h0);
        step();
        chk("vblank_held", 32'(bus.o_VBlank_Tick), 32'h0);
        bus.i_VBlank = 0;
        step();
        chk("vblank_fall", 32'(bus.o_VBlank_Tick), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
